// File: rtl/pacman_motion.sv
// Pac-Man movement controller: buffers direction requests and steps the
// sprite one pixel per movement tick using the collision-checker flags.
module pacman_motion #(
  parameter int START_X   = 140,
  parameter int START_Y   = 234,
  parameter int TICK_DIV  = 1_250_000,
  parameter int REQ_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       can_left,
  input  logic       can_right,
  input  logic       can_up,
  input  logic       can_down,
  output logic [8:0] x_pos_pixel,
  output logic [8:0] y_pos_pixel,
  output logic [1:0] dir,
  output logic       moving,
  output logic       step
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(REQ_TICKS + 1);

  localparam logic [1:0] D_LEFT  = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic          moving_q, moving_d;
  logic          step_q, step_d;
  logic          req_valid_q, req_valid_d;
  logic [1:0]    req_dir_q, req_dir_d;
  logic [AW-1:0] req_age_q, req_age_d;

  logic       tick;
  logic       tunnel;
  logic [3:0] can_eff;
  logic       btn_any;
  logic [1:0] btn_dir;
  logic       take;
  logic       go;
  logic [1:0] go_dir;
  logic [8:0] nx, ny;

  assign tick   = enable && (tick_cnt_q == CW'(TICK_DIV - 1));
  assign tunnel = (y_q >= 9'd140) && (y_q <= 9'd149);

  // Tunnel ends force the horizontal flags, the checker looks off-grid there
  assign can_eff[D_LEFT]  = can_left  | (tunnel & (x_q < 9'd6));
  assign can_eff[D_RIGHT] = can_right | (tunnel & (x_q > 9'd273));
  assign can_eff[D_UP]    = can_up;
  assign can_eff[D_DOWN]  = can_down;

  assign btn_any = btn_left | btn_right | btn_up | btn_down;

  always_comb begin
    btn_dir = D_LEFT;
    priority case (1'b1)
      btn_left:  btn_dir = D_LEFT;
      btn_right: btn_dir = D_RIGHT;
      btn_up:    btn_dir = D_UP;
      btn_down:  btn_dir = D_DOWN;
      default:   btn_dir = D_LEFT;
    endcase
  end

  assign take   = req_valid_q && can_eff[req_dir_q];
  assign go_dir = take ? req_dir_q : dir_q;
  assign go     = take || can_eff[dir_q];

  always_comb begin
    nx = x_q;
    ny = y_q;
    unique case (go_dir)
      D_LEFT:
        nx = (x_q == 9'd0) ? (tunnel ? 9'd279 : 9'd0) : x_q - 9'd1;
      D_RIGHT:
        nx = (x_q >= 9'd279) ? (tunnel ? 9'd0 : 9'd279) : x_q + 9'd1;
      D_UP:
        ny = y_q + 9'd1;
      D_DOWN:
        ny = y_q - 9'd1;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    moving_d   = moving_q;
    step_d     = 1'b0;
    if (!enable || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
    if (tick) begin
      moving_d = go;
      if (go) begin
        x_d    = nx;
        y_d    = ny;
        dir_d  = go_dir;
        step_d = (nx != x_q) || (ny != y_q);
      end
    end
  end

  // A held button reloads every cycle, so it wins over consumption and expiry
  always_comb begin
    req_valid_d = req_valid_q;
    req_dir_d   = req_dir_q;
    req_age_d   = req_age_q;
    if (!enable) begin
      req_valid_d = 1'b0;
      req_age_d   = '0;
    end else if (btn_any) begin
      req_valid_d = 1'b1;
      req_dir_d   = btn_dir;
      req_age_d   = '0;
    end else if (tick && req_valid_q) begin
      if (take) begin
        req_valid_d = 1'b0;
      end else begin
        req_age_d = req_age_q + AW'(1);
        if (req_age_q + AW'(1) == AW'(REQ_TICKS))
          req_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      x_q         <= 9'(START_X);
      y_q         <= 9'(START_Y);
      dir_q       <= D_LEFT;
      moving_q    <= 1'b0;
      step_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_dir_q   <= D_LEFT;
      req_age_q   <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      moving_q    <= moving_d;
      step_q      <= step_d;
      req_valid_q <= req_valid_d;
      req_dir_q   <= req_dir_d;
      req_age_q   <= req_age_d;
    end
  end

  assign x_pos_pixel = x_q;
  assign y_pos_pixel = y_q;
  assign dir         = dir_q;
  assign moving      = moving_q;
  assign step        = step_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: directed maze scenarios plus random play,
// all outputs compared every cycle against a behavioural model.
module tb_pacman_motion;

  localparam int TD = 4;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       btn_l, btn_r, btn_u, btn_d;
  logic       cl, cr, cu, cd;
  logic [8:0] xo, yo;
  logic [1:0] dir_o;
  logic       mov_o, step_o;

  pacman_motion #(
    .START_X  (140),
    .START_Y  (234),
    .TICK_DIV (TD),
    .REQ_TICKS(RT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn_left   (btn_l),
    .btn_right  (btn_r),
    .btn_up     (btn_u),
    .btn_down   (btn_d),
    .can_left   (cl),
    .can_right  (cr),
    .can_up     (cu),
    .can_down   (cd),
    .x_pos_pixel(xo),
    .y_pos_pixel(yo),
    .dir        (dir_o),
    .moving     (mov_o),
    .step       (step_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int dx[4] = '{-1, 1, 0, 0};
  int dy[4] = '{0, 0, 1, -1};

  // Model state: position, heading, request with remaining lifetime in ticks
  int m_x, m_y, m_dir, m_mov, m_step;
  int m_rv, m_rdir, m_left, m_cnt;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 140; m_y = 234; m_dir = 0; m_mov = 0; m_step = 0;
    m_rv = 0; m_rdir = 0; m_left = 0; m_cnt = 0;
  endtask

  task automatic model_clock();
    bit tick, tun, take;
    bit c[4];
    int b, nd, nx, ny;
    tick = enable && (m_cnt == TD - 1);
    tun  = (m_y >= 140) && (m_y <= 149);
    c[0] = cl || (tun && m_x < 6);
    c[1] = cr || (tun && m_x > 273);
    c[2] = cu;
    c[3] = cd;
    b = btn_l ? 0 : btn_r ? 1 : btn_u ? 2 : btn_d ? 3 : -1;
    take = 0; nd = -1; m_step = 0;
    if (tick) begin
      if (m_rv != 0 && c[m_rdir]) begin nd = m_rdir; take = 1; end
      else if (c[m_dir]) nd = m_dir;
      if (nd < 0) m_mov = 0;
      else begin
        nx = m_x + dx[nd];
        ny = m_y + dy[nd];
        if (tun) nx = (nx + 280) % 280;
        else if (nx < 0) nx = 0;
        else if (nx > 279) nx = 279;
        m_step = ((nx != m_x) || (ny != m_y)) ? 1 : 0;
        m_x = nx; m_y = ny; m_dir = nd; m_mov = 1;
      end
    end
    if (!enable) m_rv = 0;
    else if (b >= 0) begin m_rv = 1; m_rdir = b; m_left = RT; end
    else if (tick && m_rv != 0) begin
      if (take) m_rv = 0;
      else begin
        m_left--;
        if (m_left == 0) m_rv = 0;
      end
    end
    m_cnt = enable ? (m_cnt + 1) % TD : 0;
  endtask

  task automatic check_model();
    check("x", 32'(xo), m_x);
    check("y", 32'(yo), m_y);
    check("dir", 32'(dir_o), m_dir);
    check("moving", 32'(mov_o), m_mov);
    check("step", 32'(step_o), m_step);
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rand_inputs();
    bit tun;
    tun    = (m_y >= 140) && (m_y <= 149);
    btn_l  = ($urandom_range(7) == 0);
    btn_r  = ($urandom_range(7) == 0);
    btn_u  = ($urandom_range(7) == 0);
    btn_d  = ($urandom_range(7) == 0);
    cl     = ($urandom_range(3) != 0) && !(m_x == 0 && !tun);
    cr     = ($urandom_range(3) != 0) && !(m_x == 279 && !tun);
    cu     = ($urandom_range(3) != 0) && (m_y < 309);
    cd     = ($urandom_range(3) != 0) && (m_y > 0);
    enable = ($urandom_range(19) != 0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_x"}, 32'(xo), 140);
    check({tag, "_y"}, 32'(yo), 234);
    check({tag, "_dir"}, 32'(dir_o), 0);
    check({tag, "_mov"}, 32'(mov_o), 0);
    check({tag, "_step"}, 32'(step_o), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_inputs();
    btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
    cl = 0; cr = 0; cu = 0; cd = 0;
  endtask

  initial begin
    int x0;
    reset  = 1'b1;
    enable = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_x", 32'(xo), 140);
    check("rst_y", 32'(yo), 234);
    check("rst_dir", 32'(dir_o), 0);
    check("rst_mov", 32'(mov_o), 0);
    check("rst_step", 32'(step_o), 0);
    reset = 1'b0;

    // Start right from a one-cycle press
    btn_r = 1; cr = 1;
    cyc();
    btn_r = 0;
    cycn(3);
    check("start_x", 32'(xo), 141);
    check("start_dir", 32'(dir_o), 1);
    check("start_step", 32'(step_o), 1);
    cyc();
    check("start_step_off", 32'(step_o), 0);
    cycn(7);
    check("start_run_x", 32'(xo), 143);

    // Buffered turn up, blocked for one tick
    btn_u = 1; cu = 0;
    cyc();
    btn_u = 0;
    cycn(3);
    check("buf_x1", 32'(xo), 144);
    cu = 1;
    cycn(4);
    check("buf_y", 32'(yo), 235);
    check("buf_x2", 32'(xo), 144);
    check("buf_dir", 32'(dir_o), 2);

    // Down request expires after two blocked ticks
    btn_d = 1; cd = 0;
    cyc();
    btn_d = 0;
    cycn(7);
    cd = 1;
    cycn(4);
    check("exp_dir", 32'(dir_o), 2);
    check("exp_y", 32'(yo), 238);

    // Turn right then hit a wall
    cd = 0; cu = 0;
    btn_r = 1; cr = 1;
    cyc();
    btn_r = 0;
    cycn(3);
    check("wall_pre_x", 32'(xo), 145);
    cr = 0;
    cycn(4);
    check("wall_x", 32'(xo), 145);
    check("wall_mov", 32'(mov_o), 0);
    check("wall_step", 32'(step_o), 0);
    check("wall_dir", 32'(dir_o), 1);

    // Walk into the tunnel row and to its left end
    btn_d = 1; cd = 1;
    for (int i = 0; i < 2000 && m_y != 144; i++) cyc();
    check("reach_y", 32'(yo), 144);
    clear_inputs();
    btn_l = 1; cl = 1;
    for (int i = 0; i < 2000 && m_x != 0; i++) cyc();
    check("reach_x0", 32'(xo), 0);
    clear_inputs();
    cycn(4);
    check("wrap_l_x", 32'(xo), 279);
    check("wrap_l_dir", 32'(dir_o), 0);
    btn_r = 1;
    cyc();
    btn_r = 0;
    cycn(3);
    check("wrap_r_x", 32'(xo), 0);
    check("wrap_r_dir", 32'(dir_o), 1);

    // Enable gating clears the pending up request
    cr = 1;
    btn_u = 1;
    cyc();
    btn_u = 0;
    cyc();
    x0 = 32'(xo);
    enable = 0;
    cycn(3);
    check("frz_x", 32'(xo), x0);
    enable = 1; cu = 1;
    cycn(3);
    check("ena_x_hold", 32'(xo), x0);
    cyc();
    check("ena_x_move", 32'(xo), x0 + 1);
    check("ena_dir", 32'(dir_o), 1);
    check("ena_y", 32'(yo), 144);

    async_reset_check("arst1");

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end
    async_reset_check("arst2");
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_motion.md
# pacman_motion

Pac-Man movement controller, sitting directly downstream of the wall-collision checker. It registers Pac-Man's pixel position on the 280×310 maze grid (28×31 tiles, 10 px per tile) and buffers the player's direction request. At a fixed step rate it moves the sprite one pixel, using the checker's `can_left/right/up/down` flags, which are computed combinationally from this block's own position outputs. Its outputs feed back into the collision checker and drive the sprite renderer and animation.

## Interface
Parameters:
- `START_X`, default 140: reset x pixel (between tiles 13 and 14).
- `START_Y`, default 234: reset y pixel (row 23, vertically centred).
- `TICK_DIV`, default 1_250_000: clock cycles per movement step (80 px/s at 100 MHz); must be ≥ 2.
- `REQ_TICKS`, default 16: number of movement steps a buffered request survives.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: game running; when low, all motion is frozen.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`, in, 1 each: debounced level inputs.
- `can_left`, `can_right`, `can_up`, `can_down`, in, 1 each: collision-checker flags for the current position.
- `x_pos_pixel`, out, 9: registered x position, range 0..279.
- `y_pos_pixel`, out, 9: registered y position, range 0..309.
- `dir`, out, 2: current heading (0 = LEFT, 1 = RIGHT, 2 = UP, 3 = DOWN).
- `moving`, out, 1: high while the last step succeeded.
- `step`, out, 1: one-cycle pulse, high in the cycle after each position change.

## Operation
- **Direction convention** (matches the collision checker): LEFT is x−1, RIGHT is x+1, UP is y+1, DOWN is y−1.
- **Tick counter**
  - `tick_cnt` counts 0..TICK_DIV−1 while `enable` is high.
  - `tick` is asserted in the cycle where `tick_cnt == TICK_DIV−1`; the counter then wraps to 0.
  - When `enable` is low, the counter is held at 0, no tick occurs, and the pending request is cleared.
- **Request buffer** (`req_valid`, `req_dir`, `req_age`)
  - Any button high loads `req_dir`, sets `req_valid`, and clears `req_age`.
  - Priority when several buttons are high: LEFT > RIGHT > UP > DOWN.
  - A newer press overwrites any older request.
  - On each tick where the request is not consumed, `req_age` increments. When `req_age` reaches REQ_TICKS, `req_valid` is cleared.
  - A button level that is still held reloads the request every cycle, so holding a button never lets it expire.
- **Step decision**, evaluated on each tick using the registered request:
  1. If `req_valid` and `can[req_dir]`: set `dir` to `req_dir`, set `moving` to 1, clear `req_valid`, and move one pixel in `req_dir`.
  2. Else, if `can[dir]`: set `moving` to 1 and move one pixel in `dir`. This also restarts motion after a stop if the wall is gone.
  3. Else: set `moving` to 0; position and `dir` are unchanged, and no `step` pulse is produced.
- **Tunnel row** (row 14, i.e. `y_pos_pixel` 140..149):
  - When x < 6, `can_left` is treated as 1; when x > 273, `can_right` is treated as 1. This covers the out-of-range lookups in the checker.
  - Moving LEFT from x = 0 gives x = 279; moving RIGHT from x = 279 gives x = 0.
  - Outside the tunnel row, x never goes below 0 or above 279.
- **Reversal** goes through the same path as any other turn; it is legal whenever the corresponding `can_*` flag is high.
- **Arithmetic**: 9-bit unsigned; wrap only as specified above. No other overflow can occur because maze walls bound all other movement.

## Timing
- **Reset values**: `x_pos_pixel` = START_X, `y_pos_pixel` = START_Y, `dir` = 0 (LEFT), `moving` = 0, `step` = 0, `req_valid` = 0, `tick_cnt` = 0, `req_age` = 0. Reset acts immediately, mid-step included.
- **Position latency**: position, `dir`, and `moving` update on the clock edge that ends the tick cycle. `step` is high for the following single cycle.
- **`can_*` sampling**: flags are sampled in the tick cycle and correspond to the position held during that cycle.
- **Button-to-tick ordering**: a button first seen in the tick cycle itself is ignored for that tick and is evaluated at the next tick.
- **Release timing**: the request is registered one cycle after the button is seen; a button released before the next tick still produces a valid request.
- **Step rate**: at most one pixel moves per TICK_DIV cycles.

## Test plan
All scenarios use TICK_DIV = 4 and REQ_TICKS = 2.
- **Reset**: assert `reset` → outputs are x = 140, y = 234, `dir` = 0, `moving` = 0, `step` = 0. Assert `reset` mid-motion at x = 150 → x = 140 immediately, with no clock needed.
- **Start right**: one-cycle `btn_right` pulse, `can_right` = 1 → at the next tick x = 141, `dir` = 1, `moving` = 1, one `step` pulse; after that x increments every 4 cycles.
- **Buffered turn**: while moving right, pulse `btn_up` with `can_up` = 0 for 1 tick, then `can_up` = 1 on the 2nd tick → y +1, x unchanged, `dir` = 2.
- **Expiry and wall stop**: pulse `btn_down` with `can_down` = 0 for 2 ticks, then raise it → no turn. With `can_right` = 0 at a tick → x unchanged, `moving` = 0, no `step`, `dir` stays 1.
- **Tunnel wrap**: y = 144, x = 0, `dir` = LEFT, `can_left` = 0 → next tick x = 279. Then at x = 279 moving RIGHT → x = 0.
- **Enable gating**: drop `enable` mid-count while moving → position frozen, `tick_cnt` = 0, request cleared. Re-raise `enable` → first move occurs exactly 4 cycles later.
